// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC flash bus target: command codes, status byte
// and the target FSM state encoding.
package nfc_pkg;

  localparam logic [7:0] CMD_READ0    = 8'h00;
  localparam logic [7:0] CMD_READ1    = 8'h01;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_CFM = 8'h10;
  localparam logic [7:0] CMD_STATUS   = 8'h70;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // bit7 = not write-protected, bit6 = ready, bit0 = pass (0)
  localparam logic [7:0] STATUS_READY = 8'hC0;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR1    = 4'd1,
    ST_ADDR2    = 4'd2,
    ST_ADDR3    = 4'd3,
    ST_RD_BUSY  = 4'd4,
    ST_RD_DATA  = 4'd5,
    ST_PG_DATA  = 4'd6,
    ST_PG_BUSY  = 4'd7,
    ST_STATUS   = 4'd8,
    ST_RST_BUSY = 4'd9
  } state_t;

  // States in which F_RB is low and only FFh is honoured
  function automatic logic is_busy(input state_t s);
    return (s == ST_RD_BUSY) || (s == ST_PG_BUSY) || (s == ST_RST_BUSY);
  endfunction

endpackage

// File: rtl/nand_flash_target_if.sv
// Flash-bus bundle between the NFC (master) and the flash target (slave).
// Handshake: the NFC owns CLE/ALE/WEN/REN/F_IO_in; a byte is transferred on
// each WEN rising edge, read data is requested on each REN falling edge, and
// the target signals readiness on F_RB (1 = ready). F_IO_out is meaningful
// only while F_IO_oe is 1.
interface nand_flash_target_if;
  logic [7:0] F_IO_in;
  logic [7:0] F_IO_out;
  logic       F_IO_oe;
  logic       F_CLE;
  logic       F_ALE;
  logic       F_WEN;
  logic       F_REN;
  logic       F_RB;

  modport master (
    output F_IO_in, F_CLE, F_ALE, F_WEN, F_REN,
    input  F_IO_out, F_IO_oe, F_RB
  );

  modport slave (
    input  F_IO_in, F_CLE, F_ALE, F_WEN, F_REN,
    output F_IO_out, F_IO_oe, F_RB
  );
endinterface

// File: rtl/nfc_strobe_edge.sv
// Samples the flash-bus strobes once per clock and produces single-cycle
// WEN-rise / REN-fall events together with the byte, CLE and ALE that were
// sampled on the clock before the WEN rise.
module nfc_strobe_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wen,
  input  logic       i_ren,
  input  logic       i_cle,
  input  logic       i_ale,
  input  logic [7:0] i_io,
  output logic       o_wen_rise,
  output logic       o_ren_fall,
  output logic       o_cle,
  output logic       o_ale,
  output logic [7:0] o_byte
);

  logic       r_wen_q;
  logic       r_ren_q;
  logic       r_cle_q;
  logic       r_ale_q;
  logic [7:0] r_io_q;

  // Previous-cycle samples; strobes idle high so reset them to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen_q <= 1'b1;
      r_ren_q <= 1'b1;
      r_cle_q <= 1'b0;
      r_ale_q <= 1'b0;
      r_io_q  <= 8'h00;
    end else begin
      r_wen_q <= i_wen;
      r_ren_q <= i_ren;
      r_cle_q <= i_cle;
      r_ale_q <= i_ale;
      r_io_q  <= i_io;
    end
  end

  assign o_wen_rise = i_wen & ~r_wen_q;
  assign o_ren_fall = ~i_ren & r_ren_q;
  assign o_cle      = r_cle_q;
  assign o_ale      = r_ale_q;
  assign o_byte     = r_io_q;

endmodule

// File: rtl/nand_flash_target.sv
// Device-side NAND flash model: decodes NFC strobes, latches commands,
// addresses and program data, sources read data from a flat byte array and
// drives F_RB busy/ready. One instance per channel.
module nand_flash_target
  import nfc_pkg::*;
#(
  parameter int COL_W  = 9,
  parameter int ROW_W  = 16,
  parameter int T_BUSY = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nand_flash_target_if.slave     bus,
  output logic [ROW_W+COL_W-1:0] arr_addr,
  output logic                   arr_re,
  output logic                   arr_we,
  output logic [7:0]             arr_wdata,
  input  logic [7:0]             arr_rdata,
  output state_t                 o_dbg_state
);

  localparam int CNT_W = (T_BUSY > 1) ? $clog2(T_BUSY) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(T_BUSY - 1);

  // Decoded bus events
  logic       w_wen_rise;
  logic       w_ren_fall;
  logic       w_cle;
  logic       w_ale;
  logic [7:0] w_byte;

  nfc_strobe_edge u_strobe (
    .clk        (clk),
    .rst        (rst),
    .i_wen      (bus.F_WEN),
    .i_ren      (bus.F_REN),
    .i_cle      (bus.F_CLE),
    .i_ale      (bus.F_ALE),
    .i_io       (bus.F_IO_in),
    .o_wen_rise (w_wen_rise),
    .o_ren_fall (w_ren_fall),
    .o_cle      (w_cle),
    .o_ale      (w_ale),
    .o_byte     (w_byte)
  );

  // Registered state
  state_t                   r_state;
  logic [ROW_W-1:0]         r_row;
  logic [COL_W-1:0]         r_col;
  logic                     r_op_rd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_rb;
  logic                     r_oe;
  logic [7:0]               r_io_out;
  logic [ROW_W+COL_W-1:0]   r_arr_addr;
  logic                     r_arr_re;
  logic                     r_arr_we;
  logic [7:0]               r_arr_wdata;
  logic                     r_rd_pend;

  // Next-state values
  state_t                   w_state_nxt;
  logic [ROW_W-1:0]         w_row_nxt;
  logic [COL_W-1:0]         w_col_nxt;
  logic                     w_op_rd_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_rb_nxt;
  logic                     w_oe_nxt;
  logic [7:0]               w_io_out_nxt;
  logic [ROW_W+COL_W-1:0]   w_addr_nxt;
  logic                     w_re_nxt;
  logic                     w_we_nxt;
  logic [7:0]               w_wdata_nxt;
  logic                     w_rd_pend_nxt;
  logic                     w_busy;

  // State and datapath registers; reset returns every output to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_op_rd     <= 1'b0;
      r_cnt       <= '0;
      r_rb        <= 1'b1;
      r_oe        <= 1'b0;
      r_io_out    <= 8'h00;
      r_arr_addr  <= '0;
      r_arr_re    <= 1'b0;
      r_arr_we    <= 1'b0;
      r_arr_wdata <= 8'h00;
      r_rd_pend   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_op_rd     <= w_op_rd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rb        <= w_rb_nxt;
      r_oe        <= w_oe_nxt;
      r_io_out    <= w_io_out_nxt;
      r_arr_addr  <= w_addr_nxt;
      r_arr_re    <= w_re_nxt;
      r_arr_we    <= w_we_nxt;
      r_arr_wdata <= w_wdata_nxt;
      r_rd_pend   <= w_rd_pend_nxt;
    end
  end

  // Next-state: busy countdown, read-data return, then bus events (WEN wins over REN)
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_op_rd_nxt   = r_op_rd;
    w_cnt_nxt     = r_cnt;
    w_rb_nxt      = r_rb;
    w_oe_nxt      = r_oe;
    w_io_out_nxt  = r_io_out;
    w_addr_nxt    = r_arr_addr;
    w_re_nxt      = 1'b0;
    w_we_nxt      = 1'b0;
    w_wdata_nxt   = r_arr_wdata;
    w_rd_pend_nxt = r_arr_re;
    w_busy        = is_busy(r_state);

    // Busy phase ends when the counter has run out
    if (w_busy) begin
      if (r_cnt == '0) begin
        w_rb_nxt    = 1'b1;
        w_state_nxt = (r_state == ST_RD_BUSY) ? ST_RD_DATA : ST_IDLE;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end

    // Array data arrives the cycle after the read strobe was seen by the array
    if (r_rd_pend) begin
      w_io_out_nxt = arr_rdata;
      w_oe_nxt     = 1'b1;
    end
    if (bus.F_REN) begin
      w_oe_nxt = 1'b0;
    end

    if (w_wen_rise) begin
      if (w_cle && !w_ale) begin
        if (w_byte == CMD_RESET) begin
          w_state_nxt = ST_RST_BUSY;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_op_rd_nxt = 1'b0;
          w_cnt_nxt   = BUSY_LOAD;
          w_rb_nxt    = 1'b0;
        end else if (!w_busy) begin
          case (w_byte)
            CMD_READ0, CMD_READ1, CMD_PROG: begin
              w_state_nxt          = ST_ADDR1;
              w_op_rd_nxt          = (w_byte != CMD_PROG);
              w_col_nxt[COL_W-1]   = (w_byte == CMD_READ1);
            end
            CMD_PROG_CFM: begin
              if (r_state == ST_PG_DATA) begin
                w_state_nxt = ST_PG_BUSY;
                w_cnt_nxt   = BUSY_LOAD;
                w_rb_nxt    = 1'b0;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
            CMD_STATUS: w_state_nxt = ST_STATUS;
            default: ;
          endcase
        end
      end else if (w_ale && !w_cle) begin
        if (!w_busy) begin
          case (r_state)
            ST_ADDR1: begin
              w_col_nxt[7:0] = w_byte;
              w_state_nxt    = ST_ADDR2;
            end
            ST_ADDR2: begin
              w_row_nxt[7:0] = w_byte;
              w_state_nxt    = ST_ADDR3;
            end
            ST_ADDR3: begin
              w_row_nxt[ROW_W-1:8] = w_byte[ROW_W-9:0];
              if (r_op_rd) begin
                w_state_nxt = ST_RD_BUSY;
                w_cnt_nxt   = BUSY_LOAD;
                w_rb_nxt    = 1'b0;
              end else begin
                w_state_nxt = ST_PG_DATA;
              end
            end
            default: ;
          endcase
        end
      end else if (!w_cle && !w_ale && (r_state == ST_PG_DATA)) begin
        w_we_nxt    = 1'b1;
        w_wdata_nxt = w_byte;
        w_addr_nxt  = {r_row, r_col};
        w_col_nxt   = r_col + COL_W'(1);
      end
    end else if (w_ren_fall && !w_busy) begin
      case (r_state)
        ST_RD_DATA: begin
          w_re_nxt   = 1'b1;
          w_addr_nxt = {r_row, r_col};
          w_col_nxt  = r_col + COL_W'(1);
        end
        ST_STATUS: begin
          w_io_out_nxt = STATUS_READY;
          w_oe_nxt     = 1'b1;
        end
        default: ;
      endcase
    end

    // Only the read-data and status phases may drive the bus
    if ((w_state_nxt != ST_RD_DATA) && (w_state_nxt != ST_STATUS)) begin
      w_oe_nxt = 1'b0;
    end
  end

  assign bus.F_IO_out = r_io_out;
  assign bus.F_IO_oe  = r_oe;
  assign bus.F_RB     = r_rb;
  assign arr_addr     = r_arr_addr;
  assign arr_re       = r_arr_re;
  assign arr_we       = r_arr_we;
  assign arr_wdata    = r_arr_wdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_nand_flash_target.sv
// Directed bench for nand_flash_target: program, read with column wrap,
// status, busy guard, illegal writes and mid-operation reset.
module tb_nand_flash_target;
  import nfc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nand_flash_target_if bus ();

  logic [24:0] arr_addr;
  logic        arr_re;
  logic        arr_we;
  logic [7:0]  arr_wdata;
  logic [7:0]  arr_rdata = 8'h00;
  state_t      dbg_state;

  nand_flash_target dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .arr_addr    (arr_addr),
    .arr_re      (arr_re),
    .arr_we      (arr_we),
    .arr_wdata   (arr_wdata),
    .arr_rdata   (arr_rdata),
    .o_dbg_state (dbg_state)
  );

  // Array model: synchronous read, data = addr[7:0] ^ addr[15:8] ^ 5Ah
  always @(posedge clk) begin
    if (arr_re) arr_rdata <= arr_addr[7:0] ^ arr_addr[15:8] ^ 8'h5A;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_wr_q[$];
  logic [24:0] obs_rd_q[$];

  always @(negedge clk) begin
    if (arr_we) obs_wr_q.push_back({arr_addr, arr_wdata});
    if (arr_re) obs_rd_q.push_back(arr_addr);
  end

  task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check_val({tag, "_count"}, 40'(obs_wr_q.size()), 40'(exp_q.size()));
    while (exp_q.size() > 0 && obs_wr_q.size() > 0)
      check_val({tag, "_data"}, 40'(obs_wr_q.pop_front()), 40'(exp_q.pop_front()));
    exp_q.delete();
    obs_wr_q.delete();
  endtask

  // ---------------- drivers ----------------
  // One bus write; returns on the negedge right after the latching WEN edge
  task automatic wr_cycle(input logic cle, input logic ale, input logic [7:0] d);
    repeat (2) @(negedge clk);
    bus.F_CLE   = cle;
    bus.F_ALE   = ale;
    bus.F_IO_in = d;
    bus.F_WEN   = 1'b0;
    repeat (3) @(negedge clk);
    bus.F_WEN = 1'b1;
    @(negedge clk);
    bus.F_CLE = 1'b0;
    bus.F_ALE = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c);
    wr_cycle(1'b1, 1'b0, c);
  endtask

  task automatic addr3(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    wr_cycle(1'b0, 1'b1, a1);
    wr_cycle(1'b0, 1'b1, a2);
    wr_cycle(1'b0, 1'b1, a3);
  endtask

  // One REN pulse held low 4 clocks; reports the bus while low and one cycle after release
  task automatic rd_pulse(output logic [7:0] d, output logic oe_on, output logic oe_off);
    repeat (2) @(negedge clk);
    bus.F_REN = 1'b0;
    repeat (4) @(negedge clk);
    d      = bus.F_IO_out;
    oe_on  = bus.F_IO_oe;
    bus.F_REN = 1'b1;
    @(negedge clk);
    oe_off = bus.F_IO_oe;
  endtask

  // Counts sampled busy cycles, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.F_RB == 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  rd_exp [3];
  logic [24:0] ra_exp [3];
  logic [7:0]  d;
  logic        oe_on, oe_off;
  int          nb;

  initial begin
    rd_exp[0] = 8'h81; rd_exp[1] = 8'h80; rd_exp[2] = 8'h7E;
    ra_exp[0] = 25'h025FE; ra_exp[1] = 25'h025FF; ra_exp[2] = 25'h02400;
    bus.F_IO_in = 8'h00;
    bus.F_CLE   = 1'b0;
    bus.F_ALE   = 1'b0;
    bus.F_WEN   = 1'b1;
    bus.F_REN   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_rb",    40'(bus.F_RB),     40'h1);
    check_val("rst_oe",    40'(bus.F_IO_oe),  40'h0);
    check_val("rst_io",    40'(bus.F_IO_out), 40'h00);
    check_val("rst_re_we", 40'({arr_re, arr_we}), 40'h0);
    check_val("rst_addr",  40'(arr_addr),     40'h0);
    check_val("rst_state", 40'(dbg_state),    40'(ST_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Program two bytes at row 0x12, col 0x005
    cmd(CMD_PROG);
    addr3(8'h05, 8'h12, 8'h00);
    check_val("pg_state", 40'(dbg_state), 40'(ST_PG_DATA));
    wr_cycle(1'b0, 1'b0, 8'hA5);
    wr_cycle(1'b0, 1'b0, 8'h5A);
    exp_q.push_back({25'h02405, 8'hA5});
    exp_q.push_back({25'h02406, 8'h5A});
    cmd(CMD_PROG_CFM);
    check_val("pg_rb_low", 40'(bus.F_RB), 40'h0);
    wait_ready(nb);
    check_val("pg_busy_len", 40'(nb), 40'd16);
    check_val("pg_done_state", 40'(dbg_state), 40'(ST_IDLE));
    check_writes("pg_wr");

    // Read upper half at col 0x1FE, wrap within row 0x12
    cmd(CMD_READ1);
    addr3(8'hFE, 8'h12, 8'h00);
    wait_ready(nb);
    check_val("rd_busy_len", 40'(nb), 40'd16);
    check_val("rd_state", 40'(dbg_state), 40'(ST_RD_DATA));
    for (int i = 0; i < 3; i++) begin
      rd_pulse(d, oe_on, oe_off);
      check_val($sformatf("rd_data%0d", i), 40'(d), 40'(rd_exp[i]));
      check_val($sformatf("rd_oe_on%0d", i), 40'(oe_on), 40'h1);
      check_val($sformatf("rd_oe_off%0d", i), 40'(oe_off), 40'h0);
    end
    check_val("rd_count", 40'(obs_rd_q.size()), 40'd3);
    for (int i = 0; i < 3 && obs_rd_q.size() > 0; i++)
      check_val($sformatf("rd_addr%0d", i), 40'(obs_rd_q.pop_front()), 40'(ra_exp[i]));
    obs_rd_q.delete();

    // Status
    cmd(CMD_STATUS);
    check_val("st_state", 40'(dbg_state), 40'(ST_STATUS));
    rd_pulse(d, oe_on, oe_off);
    check_val("st_data", 40'(d), 40'hC0);
    check_val("st_oe_on", 40'(oe_on), 40'h1);
    check_val("st_oe_off", 40'(oe_off), 40'h0);

    // Busy guard: 80h ignored while busy, FFh restarts the full busy time
    cmd(CMD_RESET);
    check_val("bg_rb_low", 40'(bus.F_RB), 40'h0);
    cmd(CMD_PROG);
    check_val("bg_prog_ignored", 40'(dbg_state), 40'(ST_RST_BUSY));
    cmd(CMD_RESET);
    wait_ready(nb);
    check_val("bg_restart_len", 40'(nb), 40'd16);
    check_val("bg_idle", 40'(dbg_state), 40'(ST_IDLE));
    check_writes("bg_wr");

    // Illegal command and CLE=ALE=1 write, in IDLE and in PG_DATA
    cmd(8'h3C);
    check_val("il_idle_cmd", 40'(dbg_state), 40'(ST_IDLE));
    wr_cycle(1'b1, 1'b1, 8'h55);
    check_val("il_idle_both", 40'(dbg_state), 40'(ST_IDLE));
    cmd(CMD_PROG);
    addr3(8'h00, 8'h00, 8'h00);
    cmd(8'h3C);
    check_val("il_pg_cmd", 40'(dbg_state), 40'(ST_PG_DATA));
    wr_cycle(1'b1, 1'b1, 8'h66);
    check_val("il_pg_both", 40'(dbg_state), 40'(ST_PG_DATA));
    check_writes("il_wr");
    check_val("il_no_reads", 40'(obs_rd_q.size()), 40'd0);

    // Reset in the middle of PG_DATA, while a write strobe is high
    wr_cycle(1'b0, 1'b0, 8'h11);
    exp_q.push_back({25'h00000, 8'h11});
    #1;
    rst = 1'b0;
    #1;
    check_val("mr_rb", 40'(bus.F_RB), 40'h1);
    check_val("mr_oe", 40'(bus.F_IO_oe), 40'h0);
    check_val("mr_we", 40'(arr_we), 40'h0);
    check_val("mr_state", 40'(dbg_state), 40'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    check_writes("mr_wr");
    cmd(CMD_PROG);
    check_val("mr_next_prog", 40'(dbg_state), 40'(ST_ADDR1));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
